lsu_byte_sequencer: RTL and testbench

- Load/store initiator between the single-cycle core's memory-stage controls and a byte-wide data memory port.
- Accepts one word, halfword or byte access from the core.
- Splits the access into big-endian byte transactions over a req/ack memory interface; byte k of the access goes to address addr+k.
- For loads, assembles the returned bytes and sign- or zero-extends the result.
- Detects misaligned or illegal accesses and reports them without generating memory traffic.

---
 rtl/lsu_byte_sequencer.sv | 182 ++++++++++++++++++
 tb/tb_lsu_byte_sequencer.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_byte_sequencer.sv
// Splits core word/half/byte accesses into big-endian byte transactions on a req/ack port.
// Optional macro LSU_TIMEOUT_EN aborts a transaction left unacknowledged for TIMEOUT_CYC cycles.
module lsu_byte_sequencer #(
  parameter int ADDR_W      = 32,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [31:0]       wdata_i,
  input  logic [1:0]        size_i,
  input  logic              unsigned_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o,
  output logic [31:0]       rdata_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [7:0]        mem_wdata_o,
  input  logic [7:0]        mem_rdata_i,
  input  logic              mem_ack_i
);

  typedef enum logic [1:0] {S_IDLE, S_XFER, S_DONE, S_ERR} state_e;

  state_e            state_q;
  logic              we_q;
  logic [1:0]        size_q;
  logic              uns_q;
  logic [1:0]        rem_q;
  logic [23:0]       asm_q;
  logic [31:0]       wdata_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic              mem_req_q;
  logic              mem_we_q;
  logic              busy_q;
  logic              done_q;
  logic              err_q;
  logic [31:0]       rdata_q;
  logic              bad_access_s;

`ifdef LSU_TIMEOUT_EN
  logic [31:0]       tmo_q;
`else
  localparam int unused_timeout_cyc = TIMEOUT_CYC;
`endif

  function automatic logic [31:0] extend_load(input logic [31:0] raw,
                                              input logic [1:0]  size,
                                              input logic        uns);
    case (size)
      2'b10:   return uns ? {16'h0000, raw[15:0]} : {{16{raw[15]}}, raw[15:0]};
      2'b01:   return uns ? {24'h000000, raw[7:0]} : {{24{raw[7]}}, raw[7:0]};
      default: return raw;
    endcase
  endfunction

  // Illegal size or misalignment is decided from the raw inputs at accept time
  always_comb begin
    bad_access_s = 1'b0;
    case (size_i)
      2'b00:   bad_access_s = 1'b1;
      2'b11:   bad_access_s = (addr_i[1:0] != 2'b00);
      2'b10:   bad_access_s = addr_i[0];
      default: bad_access_s = 1'b0;
    endcase
  end

  // Sequencer FSM; store bytes are pre-shifted so the next byte is always wdata_q[31:24]
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q    <= S_IDLE;
      we_q       <= 1'b0;
      size_q     <= 2'b00;
      uns_q      <= 1'b0;
      rem_q      <= 2'd0;
      asm_q      <= 24'h000000;
      wdata_q    <= 32'h00000000;
      mem_addr_q <= '0;
      mem_req_q  <= 1'b0;
      mem_we_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      rdata_q    <= 32'h00000000;
`ifdef LSU_TIMEOUT_EN
      tmo_q      <= 32'd0;
`endif
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (req_i) begin
            we_q       <= we_i;
            size_q     <= size_i;
            uns_q      <= unsigned_i;
            asm_q      <= 24'h000000;
            mem_addr_q <= addr_i;
            busy_q     <= 1'b1;
            case (size_i)
              2'b11:   rem_q <= 2'd3;
              2'b10:   rem_q <= 2'd1;
              default: rem_q <= 2'd0;
            endcase
            case (size_i)
              2'b10:   wdata_q <= {wdata_i[15:0], 16'h0000};
              2'b01:   wdata_q <= {wdata_i[7:0], 24'h000000};
              default: wdata_q <= wdata_i;
            endcase
`ifdef LSU_TIMEOUT_EN
            tmo_q <= 32'd0;
`endif
            if (bad_access_s) begin
              state_q <= S_ERR;
              done_q  <= 1'b1;
              err_q   <= 1'b1;
            end else begin
              state_q   <= S_XFER;
              mem_req_q <= 1'b1;
              mem_we_q  <= we_i;
            end
          end
        end
        S_XFER: begin
          if (mem_ack_i) begin
            asm_q      <= {asm_q[15:0], mem_rdata_i};
            wdata_q    <= {wdata_q[23:0], 8'h00};
            mem_addr_q <= mem_addr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
            rem_q      <= rem_q - 2'd1;
`ifdef LSU_TIMEOUT_EN
            tmo_q      <= 32'd0;
`endif
            if (rem_q == 2'd0) begin
              state_q   <= S_DONE;
              mem_req_q <= 1'b0;
              mem_we_q  <= 1'b0;
              done_q    <= 1'b1;
              if (!we_q) begin
                rdata_q <= extend_load({asm_q, mem_rdata_i}, size_q, uns_q);
              end
            end
          end
`ifdef LSU_TIMEOUT_EN
          else if (tmo_q == 32'(TIMEOUT_CYC - 1)) begin
            state_q   <= S_ERR;
            mem_req_q <= 1'b0;
            mem_we_q  <= 1'b0;
            done_q    <= 1'b1;
            err_q     <= 1'b1;
          end else begin
            tmo_q <= tmo_q + 32'd1;
          end
`endif
        end
        S_DONE, S_ERR: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          busy_q    <= 1'b0;
          mem_req_q <= 1'b0;
          mem_we_q  <= 1'b0;
          state_q   <= S_IDLE;
        end
      endcase
    end
  end

  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign err_o       = err_q;
  assign rdata_o     = rdata_q;
  assign mem_req_o   = mem_req_q;
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = wdata_q[31:24];

endmodule

// File: tb/tb_lsu_byte_sequencer.sv
// Directed self-checking bench for lsu_byte_sequencer; timeout scenario runs when LSU_TIMEOUT_EN is defined.
module tb_lsu_byte_sequencer;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        req_i, we_i, unsigned_i;
  logic [31:0] addr_i, wdata_i;
  logic [1:0]  size_i;
  logic        busy_o, done_o, err_o;
  logic [31:0] rdata_o;
  logic        mem_req_o, mem_we_o;
  logic [31:0] mem_addr_o;
  logic [7:0]  mem_wdata_o, mem_rdata_i;
  logic        mem_ack_i;

  logic [7:0]  tb_mem [256];
  int          n_checks = 0;
  int          n_fail = 0;

  always #5 clk_i = ~clk_i;

  assign mem_rdata_i = tb_mem[mem_addr_o[7:0]];

  lsu_byte_sequencer #(.ADDR_W(32), .TIMEOUT_CYC(8)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .req_i(req_i), .we_i(we_i), .addr_i(addr_i),
    .wdata_i(wdata_i), .size_i(size_i), .unsigned_i(unsigned_i), .busy_o(busy_o),
    .done_o(done_o), .err_o(err_o), .rdata_o(rdata_o), .mem_req_o(mem_req_o),
    .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_rdata_i(mem_rdata_i), .mem_ack_i(mem_ack_i)
  );

  // Drive a request for one cycle, then wait (bounded) for done_o; cyc counts cycles after accept.
  task automatic run_access(input logic we, input logic [1:0] size, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic uns,
                            output int cyc, output logic err);
    @(negedge clk_i);
    req_i = 1'b1; we_i = we; size_i = size; addr_i = addr; wdata_i = wdata; unsigned_i = uns;
    @(negedge clk_i);
    req_i = 1'b0;
    cyc = 1;
    while (!done_o && cyc < 40) begin
      @(negedge clk_i);
      cyc++;
    end
    err = err_o;
    n_checks++;
    if (!done_o) begin
      n_fail++;
      $display("FAIL access_timeout: done_o=%b after %0d cycles, required 1", done_o, cyc);
    end
  endtask

  task automatic test_reset();
    rst_i = 1'b0; req_i = 1'b0; we_i = 1'b0; addr_i = 32'h0; wdata_i = 32'h0;
    size_i = 2'b00; unsigned_i = 1'b0; mem_ack_i = 1'b0;
    repeat (2) @(negedge clk_i);
    n_checks++;
    if ({busy_o, done_o, err_o, mem_req_o, mem_we_o} !== 5'b00000 || rdata_o !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: ctl=%b rdata=%h, required 00000 / 00000000",
               {busy_o, done_o, err_o, mem_req_o, mem_we_o}, rdata_o);
    end
    rst_i = 1'b1;
  endtask

  task automatic test_store_word();
    logic [7:0] exp_b [4];
    exp_b[0] = 8'hA1; exp_b[1] = 8'hB2; exp_b[2] = 8'hC3; exp_b[3] = 8'hD4;
    mem_ack_i = 1'b1;
    @(negedge clk_i);
    req_i = 1'b1; we_i = 1'b1; size_i = 2'b11; addr_i = 32'h10; wdata_i = 32'hA1B2C3D4;
    @(negedge clk_i);
    req_i = 1'b0;
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if (mem_req_o !== 1'b1 || mem_we_o !== 1'b1 || mem_addr_o !== 32'h10 + k ||
          mem_wdata_o !== exp_b[k] || done_o !== 1'b0 || busy_o !== 1'b1) begin
        n_fail++;
        $display("FAIL store_word_byte%0d: req=%b we=%b addr=%h data=%h done=%b busy=%b, required 1 1 %h %h 0 1",
                 k, mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, done_o, busy_o, 32'h10 + k, exp_b[k]);
      end
      @(negedge clk_i);
    end
    n_checks++;
    if (done_o !== 1'b1 || err_o !== 1'b0 || mem_req_o !== 1'b0 || busy_o !== 1'b1) begin
      n_fail++;
      $display("FAIL store_word_done: done=%b err=%b req=%b busy=%b, required 1 0 0 1",
               done_o, err_o, mem_req_o, busy_o);
    end
    @(negedge clk_i);
    n_checks++;
    if (busy_o !== 1'b0 || done_o !== 1'b0) begin
      n_fail++;
      $display("FAIL store_word_idle: busy=%b done=%b, required 0 0", busy_o, done_o);
    end
  endtask

  task automatic test_load_half();
    int cyc; logic err;
    tb_mem[8'h20] = 8'h80; tb_mem[8'h21] = 8'h01;
    mem_ack_i = 1'b1;
    run_access(1'b0, 2'b10, 32'h20, 32'h0, 1'b0, cyc, err);
    n_checks++;
    if (rdata_o !== 32'hFFFF8001 || err !== 1'b0 || cyc !== 3) begin
      n_fail++;
      $display("FAIL load_half_signed: rdata=%h err=%b cyc=%0d, required ffff8001 0 3", rdata_o, err, cyc);
    end
    run_access(1'b0, 2'b10, 32'h20, 32'h0, 1'b1, cyc, err);
    n_checks++;
    if (rdata_o !== 32'h00008001 || err !== 1'b0) begin
      n_fail++;
      $display("FAIL load_half_unsigned: rdata=%h err=%b, required 00008001 0", rdata_o, err);
    end
  endtask

  task automatic test_load_byte_delayed();
    int req_cycles = 0;
    tb_mem[8'h33] = 8'hF0;
    mem_ack_i = 1'b0;
    @(negedge clk_i);
    req_i = 1'b1; we_i = 1'b0; size_i = 2'b01; addr_i = 32'h33; unsigned_i = 1'b0;
    @(negedge clk_i);
    req_i = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      if (mem_req_o === 1'b1) req_cycles++;
      n_checks++;
      if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h33 || mem_we_o !== 1'b0) begin
        n_fail++;
        $display("FAIL byte_wait_cycle%0d: req=%b addr=%h we=%b, required 1 00000033 0",
                 c, mem_req_o, mem_addr_o, mem_we_o);
      end
      if (c == 4) mem_ack_i = 1'b1;
      @(negedge clk_i);
    end
    mem_ack_i = 1'b0;
    n_checks++;
    if (done_o !== 1'b1 || mem_req_o !== 1'b0 || rdata_o !== 32'hFFFFFFF0 || req_cycles !== 4) begin
      n_fail++;
      $display("FAIL byte_delayed_done: done=%b req=%b rdata=%h req_cycles=%0d, required 1 0 fffffff0 4",
               done_o, mem_req_o, rdata_o, req_cycles);
    end
    @(negedge clk_i);
  endtask

  task automatic test_illegal();
    logic [1:0]  sz [3];
    logic [31:0] ad [3];
    sz[0] = 2'b11; ad[0] = 32'h22;
    sz[1] = 2'b10; ad[1] = 32'h21;
    sz[2] = 2'b00; ad[2] = 32'h40;
    mem_ack_i = 1'b0;
    for (int v = 0; v < 3; v++) begin
      @(negedge clk_i);
      req_i = 1'b1; we_i = 1'b0; size_i = sz[v]; addr_i = ad[v]; unsigned_i = 1'b1;
      @(negedge clk_i);
      req_i = 1'b0;
      n_checks++;
      if (done_o !== 1'b1 || err_o !== 1'b1 || mem_req_o !== 1'b0 || rdata_o !== 32'hFFFFFFF0) begin
        n_fail++;
        $display("FAIL illegal%0d_err: done=%b err=%b req=%b rdata=%h, required 1 1 0 fffffff0",
                 v, done_o, err_o, mem_req_o, rdata_o);
      end
      @(negedge clk_i);
      n_checks++;
      if (done_o !== 1'b0 || err_o !== 1'b0 || busy_o !== 1'b0 || mem_req_o !== 1'b0) begin
        n_fail++;
        $display("FAIL illegal%0d_after: done=%b err=%b busy=%b req=%b, required 0 0 0 0",
                 v, done_o, err_o, busy_o, mem_req_o);
      end
    end
  endtask

  task automatic test_back_to_back();
    tb_mem[8'h70] = 8'h12;
    mem_ack_i = 1'b1;
    @(negedge clk_i);
    req_i = 1'b1; we_i = 1'b0; size_i = 2'b01; addr_i = 32'h70; unsigned_i = 1'b1;
    @(negedge clk_i);
    n_checks++;
    if (mem_req_o !== 1'b1 || busy_o !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_first_xfer: req=%b busy=%b, required 1 1", mem_req_o, busy_o);
    end
    @(negedge clk_i);
    n_checks++;
    if (done_o !== 1'b1 || rdata_o !== 32'h00000012) begin
      n_fail++;
      $display("FAIL b2b_first_done: done=%b rdata=%h, required 1 00000012", done_o, rdata_o);
    end
    @(negedge clk_i);
    n_checks++;
    if (busy_o !== 1'b0 || mem_req_o !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_idle_gap: busy=%b req=%b, required 0 0", busy_o, mem_req_o);
    end
    @(negedge clk_i);
    req_i = 1'b0;
    n_checks++;
    if (busy_o !== 1'b1 || mem_req_o !== 1'b1 || mem_addr_o !== 32'h70) begin
      n_fail++;
      $display("FAIL b2b_second_accept: busy=%b req=%b addr=%h, required 1 1 00000070",
               busy_o, mem_req_o, mem_addr_o);
    end
    repeat (2) @(negedge clk_i);
  endtask

  task automatic test_reset_mid_access();
    int cyc; logic err;
    mem_ack_i = 1'b1;
    @(negedge clk_i);
    req_i = 1'b1; we_i = 1'b1; size_i = 2'b11; addr_i = 32'h50; wdata_i = 32'h11223344;
    @(negedge clk_i);
    req_i = 1'b0;
    @(negedge clk_i);
    n_checks++;
    if (mem_addr_o !== 32'h51 || mem_wdata_o !== 8'h22 || mem_req_o !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_mid_second_byte: addr=%h data=%h req=%b, required 00000051 22 1",
               mem_addr_o, mem_wdata_o, mem_req_o);
    end
    #2 rst_i = 1'b0;
    #1;
    n_checks++;
    if (mem_req_o !== 1'b0 || busy_o !== 1'b0 || rdata_o !== 32'h0) begin
      n_fail++;
      $display("FAIL rst_mid_abort: req=%b busy=%b rdata=%h, required 0 0 00000000",
               mem_req_o, busy_o, rdata_o);
    end
    @(negedge clk_i);
    rst_i = 1'b1;
    tb_mem[8'h60] = 8'h7F;
    run_access(1'b0, 2'b01, 32'h60, 32'h0, 1'b0, cyc, err);
    n_checks++;
    if (rdata_o !== 32'h0000007F || err !== 1'b0 || cyc !== 2) begin
      n_fail++;
      $display("FAIL rst_recover_load: rdata=%h err=%b cyc=%0d, required 0000007f 0 2", rdata_o, err, cyc);
    end
  endtask

`ifdef LSU_TIMEOUT_EN
  task automatic test_timeout();
    int req_cycles = 0;
    int cyc = 0;
    mem_ack_i = 1'b0;
    @(negedge clk_i);
    req_i = 1'b1; we_i = 1'b0; size_i = 2'b01; addr_i = 32'h90; unsigned_i = 1'b0;
    @(negedge clk_i);
    req_i = 1'b0;
    while (!done_o && cyc < 40) begin
      if (mem_req_o === 1'b1) req_cycles++;
      @(negedge clk_i);
      cyc++;
    end
    n_checks++;
    if (done_o !== 1'b1 || err_o !== 1'b1 || mem_req_o !== 1'b0 || req_cycles !== 8) begin
      n_fail++;
      $display("FAIL timeout_abort: done=%b err=%b req=%b req_cycles=%0d, required 1 1 0 8",
               done_o, err_o, mem_req_o, req_cycles);
    end
    @(negedge clk_i);
    n_checks++;
    if (busy_o !== 1'b0 || done_o !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_idle: busy=%b done=%b, required 0 0", busy_o, done_o);
    end
  endtask
`endif

  initial begin
    for (int i = 0; i < 256; i++) tb_mem[i] = 8'h00;
    test_reset();
    test_store_word();
    test_load_half();
    test_load_byte_delayed();
    test_illegal();
    test_back_to_back();
    test_reset_mid_access();
`ifdef LSU_TIMEOUT_EN
    test_timeout();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
